// File: rtl/axi_sram_pkg.sv
// Shared definitions for the SRAM-side AXI arbiter: bus width defaults and
// the transaction state encoding.
package axi_sram_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_XFER,
        WR_RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector; gnt is the index of the winning master.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt
);

    // On a tie the master that did not win last time goes next.
    always_comb begin
        if (req == 2'b11) gnt = ~last_grant;
        else              gnt = req[1];
    end

endmodule

// File: rtl/axi_sram_arbiter.sv
// Two-master to one-slave AXI arbiter: one single-beat transaction at a time,
// round-robin between masters, zero added latency once forwarding starts.
module axi_sram_arbiter
    import axi_sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wlast,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wlast,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wlast,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic              s_bvalid,
    output logic              s_bready
);

    state_t state, state_nxt;
    logic grant, grant_nxt, last_grant, last_grant_nxt;
    logic aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic aw_fire, w_fire;
    logic arb_gnt;
    logic [1:0] req;

    logic [ADDR_W-1:0] g_araddr, g_awaddr;
    logic [DATA_W-1:0] g_wdata;
    logic g_arvalid, g_awvalid, g_wvalid, g_wlast, g_rready, g_bready;

    logic [DATA_W-1:0] r_data;
    logic r_last, r_vld, ar_rdy, aw_rdy, w_rdy, b_vld;

    assign req = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (arb_gnt)
    );

    always_comb begin
        g_araddr  = grant ? m1_araddr  : m0_araddr;
        g_awaddr  = grant ? m1_awaddr  : m0_awaddr;
        g_wdata   = grant ? m1_wdata   : m0_wdata;
        g_arvalid = grant ? m1_arvalid : m0_arvalid;
        g_awvalid = grant ? m1_awvalid : m0_awvalid;
        g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
        g_wlast   = grant ? m1_wlast   : m0_wlast;
        g_rready  = grant ? m1_rready  : m0_rready;
        g_bready  = grant ? m1_bready  : m0_bready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        aw_done_nxt    = aw_done;
        w_done_nxt     = w_done;
        aw_fire        = 1'b0;
        w_fire         = 1'b0;
        s_araddr       = '0;
        s_awaddr       = '0;
        s_wdata        = '0;
        s_wlast        = 1'b0;
        s_arvalid      = 1'b0;
        s_awvalid      = 1'b0;
        s_wvalid       = 1'b0;
        s_rready       = 1'b0;
        s_bready       = 1'b0;
        r_data         = '0;
        r_last         = 1'b0;
        r_vld          = 1'b0;
        ar_rdy         = 1'b0;
        aw_rdy         = 1'b0;
        w_rdy          = 1'b0;
        b_vld          = 1'b0;

        if (state != IDLE) begin
            s_araddr = g_araddr;
            s_awaddr = g_awaddr;
            s_wdata  = g_wdata;
            s_wlast  = g_wlast;
            r_data   = s_rdata;
            r_last   = s_rlast;
        end

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = arb_gnt;
                    state_nxt = (arb_gnt ? m1_awvalid : m0_awvalid) ? WR_XFER : RD_ADDR;
                end
            end
            RD_ADDR: begin
                s_arvalid = g_arvalid;
                ar_rdy    = s_arready;
                if (g_arvalid & s_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                r_vld    = s_rvalid;
                s_rready = g_rready;
                if (s_rvalid & g_rready & s_rlast) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            WR_XFER: begin
                // A channel that already handshook is muted so no beat repeats.
                s_awvalid = g_awvalid & ~aw_done;
                aw_rdy    = s_awready & ~aw_done;
                s_wvalid  = g_wvalid & ~w_done;
                w_rdy     = s_wready & ~w_done;
                aw_fire   = g_awvalid & ~aw_done & s_awready;
                w_fire    = g_wvalid & ~w_done & s_wready;
                if ((aw_done | aw_fire) & (w_done | w_fire)) begin
                    state_nxt   = WR_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_done | aw_fire;
                    w_done_nxt  = w_done | w_fire;
                end
            end
            WR_RESP: begin
                b_vld    = s_bvalid;
                s_bready = g_bready;
                if (s_bvalid & g_bready) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_arready = ~grant & ar_rdy;
    assign m0_rvalid  = ~grant & r_vld;
    assign m0_rlast   = ~grant & r_last;
    assign m0_rdata   = grant ? '0 : r_data;
    assign m0_awready = ~grant & aw_rdy;
    assign m0_wready  = ~grant & w_rdy;
    assign m0_bvalid  = ~grant & b_vld;

    assign m1_arready = grant & ar_rdy;
    assign m1_rvalid  = grant & r_vld;
    assign m1_rlast   = grant & r_last;
    assign m1_rdata   = grant ? r_data : '0;
    assign m1_awready = grant & aw_rdy;
    assign m1_wready  = grant & w_rdy;
    assign m1_bvalid  = grant & b_vld;

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Cycle-by-cycle vector bench for axi_sram_arbiter with a small SRAM model
// standing in for the bridge.
module tb_axi_sram_arbiter;

    localparam logic [31:0] D0 = 32'h5a5a0000;
    localparam logic [31:0] D1 = 32'habcdaaaa;
    localparam logic [31:0] D2 = 32'h12345678;
    localparam logic [31:0] D3 = 32'h0badf00d;
    localparam logic [31:0] Z  = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
    logic m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
    logic m0_wlast, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
    logic m1_arvalid, m1_arready, m1_rlast, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
    logic m1_wlast, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

    axi_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    // SRAM model: latches AR/AW/W on handshake, commits the write on B.
    logic [31:0] mem [16] = '{D0, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    logic [31:0] raddr = 32'h0;
    logic [31:0] awa = 32'h0;
    logic [31:0] wd = 32'h0;
    assign s_rdata = s_rvalid ? mem[raddr[5:2]] : 32'h0;
    always @(posedge clk) begin
        if (s_arvalid && s_arready) raddr <= s_araddr;
        if (s_awvalid && s_awready) awa <= s_awaddr;
        if (s_wvalid && s_wready) wd <= s_wdata;
        if (s_bvalid && s_bready) mem[awa[5:2]] <= wd;
    end

    // mNc = {arvalid, awvalid, wvalid, wlast, rready, bready}
    // sc  = {arready, rvalid, rlast, awready, wready, bvalid}
    // xmN = {arready, rvalid, rlast, awready, wready, bvalid}
    // xs  = {arvalid, rready, awvalid, wvalid, wlast, bready}
    typedef struct {
        logic        rst;
        logic [5:0]  m0c;
        logic [31:0] m0a, m0d;
        logic [5:0]  m1c;
        logic [31:0] m1a, m1d;
        logic [5:0]  sc, xm0, xm1, xs;
        logic [31:0] xaa, xwa, xwd, xrd0, xrd1;
    } vec_t;

    vec_t tv[$];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(logic r, logic [5:0] m0c, logic [31:0] m0a, logic [31:0] m0d,
                                logic [5:0] m1c, logic [31:0] m1a, logic [31:0] m1d,
                                logic [5:0] sc, logic [5:0] xm0, logic [5:0] xm1, logic [5:0] xs,
                                logic [31:0] xaa, logic [31:0] xwa, logic [31:0] xwd,
                                logic [31:0] xrd0, logic [31:0] xrd1);
        vec_t v;
        v.rst = r; v.m0c = m0c; v.m0a = m0a; v.m0d = m0d;
        v.m1c = m1c; v.m1a = m1a; v.m1d = m1d; v.sc = sc;
        v.xm0 = xm0; v.xm1 = xm1; v.xs = xs;
        v.xaa = xaa; v.xwa = xwa; v.xwd = xwd; v.xrd0 = xrd0; v.xrd1 = xrd1;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst;
        {m0_arvalid, m0_awvalid, m0_wvalid, m0_wlast, m0_rready, m0_bready} = v.m0c;
        m0_araddr = v.m0a; m0_awaddr = v.m0a; m0_wdata = v.m0d;
        {m1_arvalid, m1_awvalid, m1_wvalid, m1_wlast, m1_rready, m1_bready} = v.m1c;
        m1_araddr = v.m1a; m1_awaddr = v.m1a; m1_wdata = v.m1d;
        {s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid} = v.sc;
    endtask

    initial begin
        apply(mk(1, 6'b0, Z, Z, 6'b0, Z, Z, 6'b0, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));

        // reset with a write already requested
        tv.push_back(mk(1, 6'b011100, 32'h4, D1, 6'b0, Z, Z, 6'b000110, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        // single m0 write 0x4, then read it back
        tv.push_back(mk(0, 6'b011100, 32'h4, D1, 6'b0, Z, Z, 6'b000110, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b011100, 32'h4, D1, 6'b0, Z, Z, 6'b000110, 6'b000110, 6'b0, 6'b001110, 32'h4, 32'h4, D1, Z, Z));
        tv.push_back(mk(0, 6'b000001, 32'h4, D1, 6'b0, Z, Z, 6'b000001, 6'b000001, 6'b0, 6'b000001, 32'h4, 32'h4, D1, Z, Z));
        tv.push_back(mk(0, 6'b100010, 32'h4, Z, 6'b0, Z, Z, 6'b100000, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b100010, 32'h4, Z, 6'b0, Z, Z, 6'b100000, 6'b100000, 6'b0, 6'b100000, 32'h4, 32'h4, Z, Z, Z));
        tv.push_back(mk(0, 6'b000010, 32'h4, Z, 6'b0, Z, Z, 6'b011000, 6'b011000, 6'b0, 6'b010000, 32'h4, 32'h4, Z, D1, Z));
        // reset between transactions restores m0 priority on ties
        tv.push_back(mk(1, 6'b0, Z, Z, 6'b0, Z, Z, 6'b0, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        // simultaneous: m0 read 0x0 wins, m1 write 0x8 waits
        tv.push_back(mk(0, 6'b100010, Z, Z, 6'b011101, 32'h8, D2, 6'b100110, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b100010, Z, Z, 6'b011101, 32'h8, D2, 6'b100110, 6'b100000, 6'b0, 6'b100000, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b000010, Z, Z, 6'b011101, 32'h8, D2, 6'b010110, 6'b010000, 6'b0, 6'b010000, Z, Z, Z, D0, Z));
        tv.push_back(mk(0, 6'b000010, Z, Z, 6'b011101, 32'h8, D2, 6'b011110, 6'b011000, 6'b0, 6'b010000, Z, Z, Z, D0, Z));
        tv.push_back(mk(0, 6'b0, Z, Z, 6'b011101, 32'h8, D2, 6'b000110, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b0, Z, Z, 6'b011101, 32'h8, D2, 6'b000110, 6'b0, 6'b000110, 6'b001110, 32'h8, 32'h8, D2, Z, Z));
        tv.push_back(mk(0, 6'b0, Z, Z, 6'b000001, 32'h8, D2, 6'b000001, 6'b0, 6'b000001, 6'b000001, 32'h8, 32'h8, D2, Z, Z));
        // m0 write 0xC: W accepted two cycles before AW
        tv.push_back(mk(0, 6'b011100, 32'hc, D3, 6'b0, Z, Z, 6'b000010, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b011100, 32'hc, D3, 6'b0, Z, Z, 6'b000010, 6'b000010, 6'b0, 6'b001110, 32'hc, 32'hc, D3, Z, Z));
        tv.push_back(mk(0, 6'b011100, 32'hc, D3, 6'b0, Z, Z, 6'b000010, 6'b0, 6'b0, 6'b001010, 32'hc, 32'hc, D3, Z, Z));
        tv.push_back(mk(0, 6'b011100, 32'hc, D3, 6'b0, Z, Z, 6'b000110, 6'b000100, 6'b0, 6'b001010, 32'hc, 32'hc, D3, Z, Z));
        tv.push_back(mk(0, 6'b000001, 32'hc, D3, 6'b0, Z, Z, 6'b000001, 6'b000001, 6'b0, 6'b000001, 32'hc, 32'hc, D3, Z, Z));
        // simultaneous again: m1 write now wins, then B backpressure for 5 cycles
        tv.push_back(mk(0, 6'b100010, Z, Z, 6'b011100, 32'h8, D2, 6'b100110, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b100010, Z, Z, 6'b011100, 32'h8, D2, 6'b100110, 6'b0, 6'b000110, 6'b001110, 32'h8, 32'h8, D2, Z, Z));
        for (int k = 0; k < 5; k++)
            tv.push_back(mk(0, 6'b100010, Z, Z, 6'b0, 32'h8, D2, 6'b100001, 6'b0, 6'b000001, 6'b0, 32'h8, 32'h8, D2, Z, Z));
        tv.push_back(mk(0, 6'b100010, Z, Z, 6'b000001, 32'h8, D2, 6'b100001, 6'b0, 6'b000001, 6'b000001, 32'h8, 32'h8, D2, Z, Z));
        // pending m0 read finally granted, then reset lands in RD_DATA
        tv.push_back(mk(0, 6'b100010, Z, Z, 6'b0, Z, Z, 6'b100000, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b100010, Z, Z, 6'b0, Z, Z, 6'b100000, 6'b100000, 6'b0, 6'b100000, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b000010, Z, Z, 6'b0, Z, Z, 6'b000000, 6'b0, 6'b0, 6'b010000, Z, Z, Z, Z, Z));
        tv.push_back(mk(1, 6'b000010, Z, Z, 6'b0, Z, Z, 6'b011000, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        // fresh m0 read of 0x4 after reset
        tv.push_back(mk(0, 6'b100010, 32'h4, Z, 6'b0, Z, Z, 6'b100000, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));
        tv.push_back(mk(0, 6'b100010, 32'h4, Z, 6'b0, Z, Z, 6'b100000, 6'b100000, 6'b0, 6'b100000, 32'h4, 32'h4, Z, Z, Z));
        tv.push_back(mk(0, 6'b000010, 32'h4, Z, 6'b0, Z, Z, 6'b011000, 6'b011000, 6'b0, 6'b010000, 32'h4, 32'h4, Z, D1, Z));
        tv.push_back(mk(0, 6'b0, Z, Z, 6'b0, Z, Z, 6'b0, 6'b0, 6'b0, 6'b0, Z, Z, Z, Z, Z));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            apply(tv[i]);
            #2;
            chk("m0ctl", i, {26'b0, m0_arready, m0_rvalid, m0_rlast, m0_awready, m0_wready, m0_bvalid}, {26'b0, tv[i].xm0});
            chk("m1ctl", i, {26'b0, m1_arready, m1_rvalid, m1_rlast, m1_awready, m1_wready, m1_bvalid}, {26'b0, tv[i].xm1});
            chk("sctl", i, {26'b0, s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready}, {26'b0, tv[i].xs});
            chk("s_araddr", i, s_araddr, tv[i].xaa);
            chk("s_awaddr", i, s_awaddr, tv[i].xwa);
            chk("s_wdata", i, s_wdata, tv[i].xwd);
            chk("m0_rdata", i, m0_rdata, tv[i].xrd0);
            chk("m1_rdata", i, m1_rdata, tv[i].xrd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
